// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//   Owns the fetch PC and drives the ifu lookup addresses. Each 64-bit line
//   returned by the ifu is split into two 32-bit instructions. Those
//   instructions are queued in a small FIFO of {pc, instr} entries and
//   presented to decode over a valid/ready handshake. A redirect flushes the
//   queue and restarts fetch at the new PC.
//
// Optional feature macro: FETCH_BUF_BYPASS_EN
//   When defined, an empty queue forwards the first word of a hitting line
//   straight to out_* in the same cycle. If decode takes it (out_ready=1),
//   the word is not stored; any second word is still enqueued.
//   When undefined, out_* comes only from the queue, with one cycle of
//   latency.
//
// Parameters
//   ADDR_W    fetch address width
//   LINE_W    ifu line width (two 32-bit instructions)
//   DEPTH     queue entries (power of 2, >= 2)
//   RESET_PC  fetch PC after reset
//
// Ports
//   clk              clock
//   rstn             synchronous reset, active high
//   instr_addr       current fetch PC to ifu
//   next_instr_addr  fetch PC for the next cycle (combinational)
//   ifu_data         line holding instr_addr
//   instr_valid      ifu hit for instr_addr this cycle
//   ifu_miss         ifu line fill in progress
//   redirect_valid   flush and restart fetch at redirect_pc
//   redirect_pc      new fetch PC (bits [1:0] ignored)
//   out_valid        out_instr/out_pc valid
//   out_ready        decode accepts the head instruction
//   out_instr        instruction to decode
//   out_pc           PC of out_instr
// -----------------------------------------------------------------------------
module fetch_buffer #(
    parameter int                 ADDR_W   = 64,
    parameter int                 LINE_W   = 64,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(64'h80000000)
) (
    input  logic              clk,
    input  logic              rstn,
    output logic [ADDR_W-1:0] instr_addr,
    output logic [ADDR_W-1:0] next_instr_addr,
    input  logic [LINE_W-1:0] ifu_data,
    input  logic              instr_valid,
    input  logic              ifu_miss,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_DEPTH  = CNT_W'(DEPTH);

    // Control state
    logic [ADDR_W-1:0] fpc;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    // Queue storage (data only, never reset)
    logic [31:0]       mem_instr [DEPTH];
    logic [ADDR_W-1:0] mem_pc    [DEPTH];

    logic [ADDR_W-1:0] fpc_nxt;
    logic [CNT_W-1:0]  free;
    logic [CNT_W-1:0]  wr_sum;
    logic [PTR_W-1:0]  wr_ptr1;
    logic [PTR_W-1:0]  wr_ptr_nxt;
    logic [1:0]        avail;
    logic [1:0]        push_n;
    logic [1:0]        enq_n;
    logic              fetch_ok;
    logic              qvalid;
    logic              qpop;
    logic              skip;
    logic [31:0]       word0;
    logic [ADDR_W-1:0] pc1;
    logic [31:0]       enq0_instr;
    logic [ADDR_W-1:0] enq0_pc;

    // Fetch, push count and output selection
    always_comb begin
        // A PC in the upper half of the line only has the high word left.
        avail    = fpc[2] ? 2'd1 : 2'd2;
        // Free slots are counted before this cycle's pop, so a popped slot
        // is never refilled in the same cycle.
        free     = CNT_DEPTH - count;
        fetch_ok = instr_valid && !ifu_miss && !redirect_valid;
        push_n   = 2'd0;
        if (fetch_ok) begin
            if (free >= CNT_W'(avail)) push_n = avail;
            else                        push_n = free[1:0];
        end

        word0  = fpc[2] ? ifu_data[63:32] : ifu_data[31:0];
        pc1    = fpc + WORD_STEP;
        qvalid = (count != '0);

`ifdef FETCH_BUF_BYPASS_EN
        // push_n is already zero in a redirect cycle, so bypass is off there.
        skip      = !qvalid && (push_n != 2'd0) && out_ready;
        out_valid = qvalid || (push_n != 2'd0);
        if (qvalid) begin
            out_instr = mem_instr[rd_ptr];
            out_pc    = mem_pc[rd_ptr];
        end else if (push_n != 2'd0) begin
            out_instr = word0;
            out_pc    = fpc;
        end else begin
            out_instr = '0;
            out_pc    = '0;
        end
`else
        skip      = 1'b0;
        out_valid = qvalid;
        out_instr = qvalid ? mem_instr[rd_ptr] : '0;
        out_pc    = qvalid ? mem_pc[rd_ptr]    : '0;
`endif

        qpop  = qvalid && out_ready && !redirect_valid;
        enq_n = push_n - {1'b0, skip};

        // When the bypassed word was consumed, the only remaining word is the
        // high half of an aligned line.
        enq0_instr = skip ? ifu_data[63:32] : word0;
        enq0_pc    = skip ? pc1             : fpc;

        wr_ptr1    = wr_ptr + PTR_ONE;
        wr_sum     = CNT_W'(wr_ptr) + CNT_W'(enq_n);
        wr_ptr_nxt = wr_sum[PTR_W-1:0];

        if (redirect_valid) fpc_nxt = redirect_pc & ALIGN_MASK;
        else                fpc_nxt = fpc + ADDR_W'({push_n, 2'b00});

        instr_addr      = fpc;
        next_instr_addr = fpc_nxt;
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rstn) begin
            fpc    <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect_valid) begin
            fpc    <= fpc_nxt;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            fpc    <= fpc_nxt;
            count  <= count + CNT_W'(enq_n) - CNT_W'(qpop);
            rd_ptr <= rd_ptr + PTR_W'(qpop);
            wr_ptr <= wr_ptr_nxt;
        end
    end

    // Queue write
    always_ff @(posedge clk) begin
        if (enq_n != 2'd0) begin
            mem_instr[wr_ptr] <= enq0_instr;
            mem_pc[wr_ptr]    <= enq0_pc;
        end
        if (enq_n == 2'd2) begin
            mem_instr[wr_ptr1] <= ifu_data[63:32];
            mem_pc[wr_ptr1]    <= pc1;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_fetch_buffer
//   Directed bench for fetch_buffer (DEPTH=4, RESET_PC=0x80000000). Each
//   scenario task drives stimulus and checks hand-computed values inline.
//   Inputs change 1 time unit after the rising edge; outputs are sampled
//   before the next rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        rstn;
    logic [63:0] instr_addr;
    logic [63:0] next_instr_addr;
    logic [63:0] ifu_data;
    logic        instr_valid;
    logic        ifu_miss;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;

    int total = 0;
    int bad   = 0;

    fetch_buffer #(
        .ADDR_W   (64),
        .LINE_W   (64),
        .DEPTH    (4),
        .RESET_PC (64'h80000000)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .instr_addr      (instr_addr),
        .next_instr_addr (next_instr_addr),
        .ifu_data        (ifu_data),
        .instr_valid     (instr_valid),
        .ifu_miss        (ifu_miss),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b1; ifu_data = '0; instr_valid = 1'b0; ifu_miss = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        step(); step();
        rstn = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if (instr_addr !== 64'h80000000) begin bad++; $display("FAIL reset_instr_addr got=%h want=80000000", instr_addr); end
        total++; if (next_instr_addr !== 64'h80000000) begin bad++; $display("FAIL reset_next_addr got=%h want=80000000", next_instr_addr); end
        total++; if (dut.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", dut.count); end
        total++; if (out_instr !== 32'h0 || out_pc !== 64'h0) begin bad++; $display("FAIL reset_out_data got=%h@%h want=0@0", out_instr, out_pc); end
    endtask

    task automatic test_split_line();
        instr_valid = 1'b1; ifu_data = 64'h00200093_00100093; out_ready = 1'b1;
        #1;
        total++; if (next_instr_addr !== 64'h80000008) begin bad++; $display("FAIL split_next_addr got=%h want=80000008", next_instr_addr); end
`ifdef FETCH_BUF_BYPASS_EN
        total++; if (out_valid !== 1'b1 || out_instr !== 32'h00100093 || out_pc !== 64'h80000000) begin bad++; $display("FAIL split_bypass_word got=%0b %h@%h want=1 00100093@80000000", out_valid, out_instr, out_pc); end
        step();
        instr_valid = 1'b0;
        #1;
`else
        step();
        instr_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b1 || out_instr !== 32'h00100093 || out_pc !== 64'h80000000) begin bad++; $display("FAIL split_word0 got=%0b %h@%h want=1 00100093@80000000", out_valid, out_instr, out_pc); end
        total++; if (instr_addr !== 64'h80000008) begin bad++; $display("FAIL split_fpc got=%h want=80000008", instr_addr); end
        step();
`endif
        total++; if (out_valid !== 1'b1 || out_instr !== 32'h00200093 || out_pc !== 64'h80000004) begin bad++; $display("FAIL split_word1 got=%0b %h@%h want=1 00200093@80000004", out_valid, out_instr, out_pc); end
        step();
        total++; if (out_valid !== 1'b0 || dut.count !== 3'd0) begin bad++; $display("FAIL split_drained got=%0b cnt=%0d want=0 cnt=0", out_valid, dut.count); end
        out_ready = 1'b0;
    endtask

    task automatic test_unaligned_redirect();
        redirect_valid = 1'b1; redirect_pc = 64'h80000106;
        #1;
        total++; if (next_instr_addr !== 64'h80000104) begin bad++; $display("FAIL unal_next_addr got=%h want=80000104", next_instr_addr); end
        step();
        redirect_valid = 1'b0; instr_valid = 1'b1; ifu_data = 64'hAAAA0001_BBBB0002;
        #1;
        total++; if (next_instr_addr !== 64'h80000108) begin bad++; $display("FAIL unal_next_after_hit got=%h want=80000108", next_instr_addr); end
        step();
        instr_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b1 || out_instr !== 32'hAAAA0001 || out_pc !== 64'h80000104) begin bad++; $display("FAIL unal_high_word got=%0b %h@%h want=1 aaaa0001@80000104", out_valid, out_instr, out_pc); end
        total++; if (dut.count !== 3'd1 || instr_addr !== 64'h80000108) begin bad++; $display("FAIL unal_state got=cnt%0d %h want=cnt1 80000108", dut.count, instr_addr); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL unal_drained got=%0b want=0", out_valid); end
    endtask

    task automatic test_full_stall();
        logic [31:0] exp_i [4];
        logic [63:0] exp_p [4];
        exp_i = '{32'h11, 32'h12, 32'h13, 32'h14};
        exp_p = '{64'h80000204, 64'h80000208, 64'h8000020c, 64'h80000210};
        redirect_valid = 1'b1; redirect_pc = 64'h80000200;
        step();
        redirect_valid = 1'b0; instr_valid = 1'b1; ifu_data = 64'h00000011_00000010;
        step();
        ifu_data = 64'h00000013_00000012;
        step();
        ifu_data = 64'h00000015_00000014;
        #1;
        total++; if (dut.count !== 3'd4 || instr_addr !== 64'h80000210) begin bad++; $display("FAIL full_fill got=cnt%0d %h want=cnt4 80000210", dut.count, instr_addr); end
        total++; if (next_instr_addr !== 64'h80000210) begin bad++; $display("FAIL full_stall_next got=%h want=80000210", next_instr_addr); end
        step();
        total++; if (dut.count !== 3'd4 || instr_addr !== 64'h80000210) begin bad++; $display("FAIL full_hold got=cnt%0d %h want=cnt4 80000210", dut.count, instr_addr); end
        out_ready = 1'b1;
        #1;
        total++; if (next_instr_addr !== 64'h80000210) begin bad++; $display("FAIL full_pop_no_reuse got=%h want=80000210", next_instr_addr); end
        step();
        out_ready = 1'b0;
        #1;
        total++; if (dut.count !== 3'd3 || out_instr !== 32'h11 || out_pc !== 64'h80000204) begin bad++; $display("FAIL full_after_pop got=cnt%0d %h@%h want=cnt3 11@80000204", dut.count, out_instr, out_pc); end
        total++; if (next_instr_addr !== 64'h80000214) begin bad++; $display("FAIL full_low_only_next got=%h want=80000214", next_instr_addr); end
        step();
        instr_valid = 1'b0;
        #1;
        total++; if (dut.count !== 3'd4 || instr_addr !== 64'h80000214) begin bad++; $display("FAIL full_refill got=cnt%0d %h want=cnt4 80000214", dut.count, instr_addr); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (out_valid !== 1'b1 || out_instr !== exp_i[i] || out_pc !== exp_p[i]) begin bad++; $display("FAIL full_drain%0d got=%0b %h@%h want=1 %h@%h", i, out_valid, out_instr, out_pc, exp_i[i], exp_p[i]); end
            step();
        end
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_empty got=%0b want=0", out_valid); end
    endtask

    task automatic test_redirect_flush();
        redirect_valid = 1'b1; redirect_pc = 64'h80000304;
        step();
        redirect_valid = 1'b0; instr_valid = 1'b1; ifu_data = 64'h00000031_00000030;
        step();
        ifu_data = 64'h00000033_00000032;
        step();
        total++; if (dut.count !== 3'd3 || instr_addr !== 64'h80000310) begin bad++; $display("FAIL flush_setup got=cnt%0d %h want=cnt3 80000310", dut.count, instr_addr); end
        redirect_valid = 1'b1; redirect_pc = 64'h80000400; out_ready = 1'b1;
        #1;
        total++; if (next_instr_addr !== 64'h80000400) begin bad++; $display("FAIL flush_next_addr got=%h want=80000400", next_instr_addr); end
        step();
        redirect_valid = 1'b0; instr_valid = 1'b0; out_ready = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || dut.count !== 3'd0) begin bad++; $display("FAIL flush_empty got=%0b cnt=%0d want=0 cnt=0", out_valid, dut.count); end
        total++; if (instr_addr !== 64'h80000400) begin bad++; $display("FAIL flush_fpc got=%h want=80000400", instr_addr); end
    endtask

    task automatic test_miss();
        ifu_miss = 1'b1; instr_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++; if (instr_addr !== 64'h80000400 || next_instr_addr !== 64'h80000400 || out_valid !== 1'b0) begin bad++; $display("FAIL miss_hold%0d got=%h %h %0b want=80000400 80000400 0", i, instr_addr, next_instr_addr, out_valid); end
            step();
        end
        ifu_miss = 1'b0; instr_valid = 1'b1; ifu_data = 64'h00000066_00000065;
        #1;
`ifdef FETCH_BUF_BYPASS_EN
        total++; if (out_valid !== 1'b1 || out_instr !== 32'h65) begin bad++; $display("FAIL miss_bypass got=%0b %h want=1 65", out_valid, out_instr); end
`else
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL miss_hit_cycle got=%0b want=0", out_valid); end
`endif
        step();
        instr_valid = 1'b0;
        #1;
        total++; if (dut.count !== 3'd2 || out_instr !== 32'h65 || out_pc !== 64'h80000400) begin bad++; $display("FAIL miss_pushed got=cnt%0d %h@%h want=cnt2 65@80000400", dut.count, out_instr, out_pc); end
        total++; if (instr_addr !== 64'h80000408) begin bad++; $display("FAIL miss_fpc got=%h want=80000408", instr_addr); end
        out_ready = 1'b1;
        step(); step();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_split_line();
        test_unaligned_redirect();
        test_full_stall();
        test_redirect_flush();
        test_miss();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
